elevator_call_scheduler: RTL and testbench
==========================================

// Module: elevator_call_scheduler
// PURPOSE
//   Latches the seven hall/car call buttons of the 3-floor car and schedules its motion.
//   Drives direction and door from the floor sensor and the door-close button.
//   Sits between the button/sensor interface and the motor/door drivers, in place of
//   ad-hoc sequencing in the elevator core. Collective-selective: serves all calls ahead
//   in the current direction before reversing.
// PARAMETERS
//   DOOR_CYCLES  8   cycles the door stays open per stop (>=2)
//   TIMER_W      4   door timer width; must hold DOOR_CYCLES
// PORTS
//   clk    in   1  system clock, all logic on posedge
//   rst    in   1  synchronous reset, active-low (rst==0 at posedge clk resets)
//   u1     in   1  hall call, floor 1 up
//   u2     in   1  hall call, floor 2 up
//   d2     in   1  hall call, floor 2 down
//   d3     in   1  hall call, floor 3 down
//   f1     in   1  car call, floor 1
//   f2     in   1  car call, floor 2
//   f3     in   1  car call, floor 3
//   dc     in   1  door-close button, level
//   fs     in   2  floor sensor: 00 between floors, 01/10/11 = floor 1/2/3
//   door   out  1  1 = door open command
//   dir    out  2  00 stop, 01 up, 10 down (11 never driven)
//   lamps  out  7  latched calls {f3,f2,f1,d3,d2,u2,u1}
// BEHAVIOUR
//   Reset: door=0, dir=00, lamps=0, cur_floor=1, state IDLE, timer=0.
//     Reset mid-move or mid-door wins immediately: all calls dropped.
//   Call latch: button high at posedge sets its bit the next cycle; bit holds until served.
//   cur_floor: loads fs when fs!=00; holds while between floors.
//   States and transitions:
//     IDLE     dir=00 door=0.
//              Call at cur_floor -> OPEN. Else call above -> UP. Else call below -> DOWN.
//              Above beats below when both exist.
//     UP       dir=01.
//              On fs=cur_floor+1, stop if: car call there, OR up call there, OR no calls above it.
//              Stop -> OPEN; dir drops to 00 the same cycle.
//     DOWN     dir=10, mirror of UP using down calls.
//     OPEN     door=1, dir=00. Timer loads DOOR_CYCLES-1 on entry, decrements each cycle.
//              Exit -> CLOSE at timer==0, or when dc==1 after >=1 open cycle.
//     CLOSE    door=0 for exactly one cycle, then:
//              calls ahead in last travel dir -> same dir;
//              else calls behind -> reverse;
//              else IDLE.
//   Service/clear: on entry to OPEN, clear the car call at cur_floor and the hall call
//     matching the travel dir. Clear both hall calls when arriving from IDLE or when
//     no calls lie ahead.
//   Same-floor press during OPEN: not latched, reloads timer to DOOR_CYCLES-1.
//     This press beats dc in the same cycle.
//   Set vs clear in the same cycle on another bit: set wins.
//   dir never changes while door=1.
//   door never asserts while fs==00.
//   Latency: button -> lamp 1 cycle; IDLE call -> dir 2 cycles; arrival -> door=1 1 cycle.
//   fs jumping by 2 floors or fs==00 while in OPEN is illegal: assertion, no recovery.
// STRUCTURE
//   elevator_pkg:
//     typedef enum state_e {IDLE,UP,DOWN,OPEN,CLOSE}
//     dir encodings DIR_STOP/DIR_UP/DIR_DOWN
//     FS_NONE/FS_F1..FS_F3
//     lamp bit indices
//   Sub-module door_timer: load/decrement/zero flag, params DOOR_CYCLES, TIMER_W.
//   Scheduler FSM, call register and ahead/behind decode stay in this module.
// TESTING
//   1. rst=0 two cycles mid-UP with lamps=7'h41 -> next cycle door=0 dir=00 lamps=0.
//   2. Idle at floor 1, f3 pulse -> lamps[6]=1; dir=01 two cycles later; fs 10 passes, no stop;
//      fs=11 -> door=1 for 8 cycles, lamps=0.
//   3. Moving up from 1 with d2 and f3 latched -> skip floor 2, serve 3, then reverse;
//      door opens at 2 and d2 clears.
//   4. Door open at floor 2, dc=1 on 3rd open cycle -> door=0 next cycle;
//      same case with f2 pressed on open cycle 6 -> timer restarts, 8 more open cycles.
//   5. Idle at floor 2, u1 and f3 same cycle -> dir=01 first (above priority);
//      floor 1 served after reversal.
//   6. Every cycle assert: door=1 implies dir=00, and dir!=11.

Source files
------------

// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and constants for the 3-floor elevator call scheduler.
// Includes the call-bit layout and per-floor masks over the latched call vector.
package elevator_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        OPEN  = 3'd3,
        CLOSE = 3'd4
    } state_e;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam logic [1:0] FS_NONE = 2'b00;
    localparam logic [1:0] FS_F1   = 2'b01;
    localparam logic [1:0] FS_F2   = 2'b10;
    localparam logic [1:0] FS_F3   = 2'b11;

    // Call vector layout: {f3,f2,f1,d3,d2,u2,u1}
    localparam int L_U1 = 0;
    localparam int L_U2 = 1;
    localparam int L_D2 = 2;
    localparam int L_D3 = 3;
    localparam int L_F1 = 4;
    localparam int L_F2 = 5;
    localparam int L_F3 = 6;

    // Every call (hall or car) that is served by stopping at floor fl.
    function automatic logic [6:0] floor_mask(input logic [1:0] fl);
        case (fl)
            FS_F1:   floor_mask = (7'd1 << L_U1) | (7'd1 << L_F1);
            FS_F2:   floor_mask = (7'd1 << L_U2) | (7'd1 << L_D2) | (7'd1 << L_F2);
            FS_F3:   floor_mask = (7'd1 << L_D3) | (7'd1 << L_F3);
            default: floor_mask = 7'd0;
        endcase
    endfunction

    // Calls strictly above floor fl.
    function automatic logic [6:0] above_mask(input logic [1:0] fl);
        case (fl)
            FS_F1:   above_mask = floor_mask(FS_F2) | floor_mask(FS_F3);
            FS_F2:   above_mask = floor_mask(FS_F3);
            default: above_mask = 7'd0;
        endcase
    endfunction

    // Calls strictly below floor fl.
    function automatic logic [6:0] below_mask(input logic [1:0] fl);
        case (fl)
            FS_F3:   below_mask = floor_mask(FS_F1) | floor_mask(FS_F2);
            FS_F2:   below_mask = floor_mask(FS_F1);
            default: below_mask = 7'd0;
        endcase
    endfunction

    // Car call plus the hall call matching upward travel at floor fl.
    function automatic logic [6:0] up_stop_mask(input logic [1:0] fl);
        case (fl)
            FS_F1:   up_stop_mask = (7'd1 << L_F1) | (7'd1 << L_U1);
            FS_F2:   up_stop_mask = (7'd1 << L_F2) | (7'd1 << L_U2);
            FS_F3:   up_stop_mask = (7'd1 << L_F3);
            default: up_stop_mask = 7'd0;
        endcase
    endfunction

    // Car call plus the hall call matching downward travel at floor fl.
    function automatic logic [6:0] down_stop_mask(input logic [1:0] fl);
        case (fl)
            FS_F1:   down_stop_mask = (7'd1 << L_F1);
            FS_F2:   down_stop_mask = (7'd1 << L_F2) | (7'd1 << L_D2);
            FS_F3:   down_stop_mask = (7'd1 << L_F3) | (7'd1 << L_D3);
            default: down_stop_mask = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_door_timer.sv
// Door dwell timer: loads DOOR_CYCLES-1, counts down to zero and holds there.
module door_timer #(
    parameter int DOOR_CYCLES = 8,
    parameter int TIMER_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(DOOR_CYCLES - 1);

    logic [TIMER_W-1:0] r_count;

    // Load has priority so a same-floor press restarts the full dwell.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective-selective scheduler for a 3-floor car: latches calls, drives
// direction and door, serves every call ahead before reversing.
// Handshake-free: buttons are sampled levels, outputs are registered commands.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 8,
    parameter int TIMER_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       u1,
    input  logic       u2,
    input  logic       d2,
    input  logic       d3,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    input  logic       dc,
    input  logic [1:0] fs,
    output logic       door,
    output logic [1:0] dir,
    output logic [6:0] lamps,
    output logic [2:0] o_state_dbg
);

    state_e      r_state;
    logic [1:0]  r_cur_floor;
    logic [1:0]  r_last_dir;
    logic [6:0]  r_calls;
    logic        r_door;
    logic [1:0]  r_dir;

    logic [6:0]  w_btn;
    logic [6:0]  w_set;
    logic [6:0]  w_clr;
    logic        w_arr_up;
    logic        w_arr_dn;
    logic        w_stop_up;
    logic        w_stop_dn;
    logic        w_idle_open;
    logic        w_same_press;
    logic        w_above;
    logic        w_below;
    logic        w_timer_zero;

    assign w_btn = {f3, f2, f1, d3, d2, u2, u1};

    // Arrival means the sensor shows the next floor in the travel direction.
    assign w_arr_up = (r_state == UP) && (fs != FS_NONE) &&
                      ({1'b0, fs} == ({1'b0, r_cur_floor} + 3'd1));
    assign w_arr_dn = (r_state == DOWN) && (fs != FS_NONE) &&
                      (({1'b0, fs} + 3'd1) == {1'b0, r_cur_floor});

    assign w_stop_up = w_arr_up && (((r_calls & up_stop_mask(fs)) != 7'd0) ||
                                    ((r_calls & above_mask(fs)) == 7'd0));
    assign w_stop_dn = w_arr_dn && (((r_calls & down_stop_mask(fs)) != 7'd0) ||
                                    ((r_calls & below_mask(fs)) == 7'd0));

    assign w_idle_open  = (r_state == IDLE) && (fs != FS_NONE) &&
                          ((r_calls & floor_mask(r_cur_floor)) != 7'd0);
    assign w_same_press = (r_state == OPEN) &&
                          ((w_btn & floor_mask(r_cur_floor)) != 7'd0);

    assign w_above = (r_calls & above_mask(r_cur_floor)) != 7'd0;
    assign w_below = (r_calls & below_mask(r_cur_floor)) != 7'd0;

    // Presses at the floor whose door is open only extend the dwell.
    assign w_set = (r_state == OPEN) ? (w_btn & ~floor_mask(r_cur_floor)) : w_btn;

    // Calls served on entry to OPEN; all of a floor is cleared when nothing lies ahead.
    always_comb begin
        w_clr = 7'd0;
        if (w_stop_up) begin
            w_clr = up_stop_mask(fs);
            if ((r_calls & above_mask(fs)) == 7'd0) w_clr = w_clr | floor_mask(fs);
        end else if (w_stop_dn) begin
            w_clr = down_stop_mask(fs);
            if ((r_calls & below_mask(fs)) == 7'd0) w_clr = w_clr | floor_mask(fs);
        end else if (w_idle_open) begin
            w_clr = floor_mask(r_cur_floor);
        end
    end

    door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES),
        .TIMER_W     (TIMER_W)
    ) u_door_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_stop_up | w_stop_dn | w_idle_open | w_same_press),
        .i_dec  (r_state == OPEN),
        .o_zero (w_timer_zero)
    );

    // Call latch (set beats clear) and last-known floor tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_calls     <= 7'd0;
            r_cur_floor <= FS_F1;
        end else begin
            r_calls <= (r_calls & ~w_clr) | w_set;
            if (fs != FS_NONE) r_cur_floor <= fs;
        end
    end

    // Scheduler FSM with registered door and direction commands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_door     <= 1'b0;
            r_dir      <= DIR_STOP;
            r_last_dir <= DIR_UP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_open) begin
                        r_state <= OPEN;
                        r_door  <= 1'b1;
                    end else if (w_above) begin
                        r_state    <= UP;
                        r_dir      <= DIR_UP;
                        r_last_dir <= DIR_UP;
                    end else if (w_below) begin
                        r_state    <= DOWN;
                        r_dir      <= DIR_DOWN;
                        r_last_dir <= DIR_DOWN;
                    end
                end
                UP, DOWN: begin
                    if (w_stop_up || w_stop_dn) begin
                        r_state <= OPEN;
                        r_door  <= 1'b1;
                        r_dir   <= DIR_STOP;
                    end
                end
                OPEN: begin
                    if (!w_same_press && (w_timer_zero || dc)) begin
                        r_state <= CLOSE;
                        r_door  <= 1'b0;
                    end
                end
                CLOSE: begin
                    if ((r_last_dir == DIR_UP) ? w_above : w_below) begin
                        r_state <= (r_last_dir == DIR_UP) ? UP : DOWN;
                        r_dir   <= r_last_dir;
                    end else if ((r_last_dir == DIR_UP) ? w_below : w_above) begin
                        r_state    <= (r_last_dir == DIR_UP) ? DOWN : UP;
                        r_dir      <= (r_last_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                        r_last_dir <= (r_last_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_door  <= 1'b0;
                    r_dir   <= DIR_STOP;
                end
            endcase
        end
    end

    // Sensor sequences the car can never legally produce.
    assert property (@(posedge clk) disable iff (!rst)
        !((r_state == OPEN) && (fs == FS_NONE)));
    assert property (@(posedge clk) disable iff (!rst)
        !(((fs == FS_F3) && (r_cur_floor == FS_F1)) ||
          ((fs == FS_F1) && (r_cur_floor == FS_F3))));

    assign door        = r_door;
    assign dir         = r_dir;
    assign lamps       = r_calls;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scenario bench for the elevator call scheduler. Door-open events are
// recorded by a monitor and matched against floors expected per scenario.
module tb_elevator_call_scheduler;
    import elevator_pkg::*;

    logic       clk;
    logic       rst;
    logic [6:0] btn;
    logic       dc;
    logic [1:0] fs;
    logic       door;
    logic [1:0] dir;
    logic [6:0] lamps;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];
    logic [1:0] obs_floor [64];
    int         obs_wr = 0;
    int         obs_rd = 0;
    logic       prev_door = 1'b0;
    int         viol_cnt = 0;

    elevator_call_scheduler #(
        .DOOR_CYCLES (8),
        .TIMER_W     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .u1          (btn[0]),
        .u2          (btn[1]),
        .d2          (btn[2]),
        .d3          (btn[3]),
        .f1          (btn[4]),
        .f2          (btn[5]),
        .f3          (btn[6]),
        .dc          (dc),
        .fs          (fs),
        .door        (door),
        .dir         (dir),
        .lamps       (lamps),
        .o_state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: records the floor at every door opening and counts invariant breaks.
    always @(negedge clk) begin
        if (rst && door && !prev_door && obs_wr < 64) begin
            obs_floor[obs_wr] = fs;
            obs_wr = obs_wr + 1;
        end
        prev_door = door;
        if (rst && ((door && dir != 2'b00) || dir == 2'b11)) viol_cnt = viol_cnt + 1;
    end

    task step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task press(input logic [6:0] b);
        btn = b;
        step(1);
        btn = 7'd0;
    endtask

    task move_one(input logic [1:0] nf);
        fs = FS_NONE;
        step($urandom_range(1, 3));
        fs = nf;
        step(1);
    endtask

    // Runs out the door dwell (bounded), then the CLOSE decision cycle.
    task wait_close(output int n);
        n = 0;
        while (door === 1'b1 && n < 40) begin
            n++;
            step(1);
        end
        checks++;
        if (n >= 40) begin errors++; $display("FAIL door_close_timeout: door=%b after %0d cycles, required 0", door, n); end
        step(1);
    endtask

    task check_served(input string name);
        logic [1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++; $display("FAIL %s_missing_open: no door opening seen, required floor %0d", name, e);
            end else begin
                if (obs_floor[obs_rd] !== e) begin
                    errors++; $display("FAIL %s_open_floor: opened at %0d, required %0d", name, obs_floor[obs_rd], e);
                end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            errors++; $display("FAIL %s_extra_open: %0d unexpected openings", name, obs_wr - obs_rd);
        end
        obs_rd = obs_wr;
    endtask

    task test_reset;
        rst = 1'b0; btn = 7'd0; dc = 1'b0; fs = FS_F1;
        step(2);
        checks++; if (door !== 1'b0) begin errors++; $display("FAIL reset_door: got %b, required 0", door); end
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL reset_dir: got %b, required 00", dir); end
        checks++; if (lamps !== 7'h00) begin errors++; $display("FAIL reset_lamps: got %h, required 00", lamps); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state_dbg); end
        rst = 1'b1;
        step(1);
    endtask

    task test_reset_mid_move;
        press(7'h40);
        step(1);
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL rmm_dir_up: got %b, required 01", dir); end
        fs = FS_NONE;
        step(1);
        press(7'h01);
        checks++; if (lamps !== 7'h41) begin errors++; $display("FAIL rmm_lamps: got %h, required 41", lamps); end
        rst = 1'b0;
        step(1);
        checks++; if (door !== 1'b0 || dir !== 2'b00 || lamps !== 7'h00) begin
            errors++; $display("FAIL rmm_after_reset: door=%b dir=%b lamps=%h, required 0/00/00", door, dir, lamps); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rmm_state: got %0d, required 0", state_dbg); end
        step(1);
        rst = 1'b1;
        fs = FS_F1;
        step(2);
        checks++; if (dir !== 2'b00 || lamps !== 7'h00) begin
            errors++; $display("FAIL rmm_stays_idle: dir=%b lamps=%h, required 00/00", dir, lamps); end
    endtask

    task test_single_call;
        int n;
        exp_q.push_back(FS_F3);
        press(7'h40);
        checks++; if (lamps !== 7'h40 || dir !== 2'b00) begin
            errors++; $display("FAIL single_latch: lamps=%h dir=%b, required 40/00", lamps, dir); end
        step(1);
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL single_dir_latency: got %b, required 01", dir); end
        move_one(FS_F2);
        checks++; if (door !== 1'b0 || dir !== 2'b01) begin
            errors++; $display("FAIL single_pass_f2: door=%b dir=%b, required 0/01", door, dir); end
        move_one(FS_F3);
        checks++; if (door !== 1'b1 || dir !== 2'b00 || lamps !== 7'h00) begin
            errors++; $display("FAIL single_arrive_f3: door=%b dir=%b lamps=%h, required 1/00/00", door, dir, lamps); end
        wait_close(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL single_open_cycles: got %0d, required 8", n); end
        checks++; if (state_dbg !== 3'd0 || dir !== 2'b00) begin
            errors++; $display("FAIL single_back_idle: state=%0d dir=%b, required 0/00", state_dbg, dir); end
        check_served("single");
    endtask

    task test_skip_reverse;
        int n;
        exp_q.push_back(FS_F1);
        press(7'h10);
        step(1);
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL skip_go_down: got %b, required 10", dir); end
        move_one(FS_F2);
        checks++; if (door !== 1'b0) begin errors++; $display("FAIL skip_pass_f2_down: door=%b, required 0", door); end
        move_one(FS_F1);
        checks++; if (door !== 1'b1) begin errors++; $display("FAIL skip_arrive_f1: door=%b, required 1", door); end
        wait_close(n);
        exp_q.push_back(FS_F3);
        exp_q.push_back(FS_F2);
        press(7'h44);
        checks++; if (lamps !== 7'h44) begin errors++; $display("FAIL skip_lamps: got %h, required 44", lamps); end
        step(1);
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL skip_go_up: got %b, required 01", dir); end
        move_one(FS_F2);
        checks++; if (door !== 1'b0 || lamps !== 7'h44) begin
            errors++; $display("FAIL skip_no_stop_f2: door=%b lamps=%h, required 0/44", door, lamps); end
        move_one(FS_F3);
        checks++; if (door !== 1'b1 || lamps !== 7'h04) begin
            errors++; $display("FAIL skip_serve_f3: door=%b lamps=%h, required 1/04", door, lamps); end
        wait_close(n);
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL skip_reverse_dir: got %b, required 10", dir); end
        move_one(FS_F2);
        checks++; if (door !== 1'b1 || lamps !== 7'h00) begin
            errors++; $display("FAIL skip_serve_d2: door=%b lamps=%h, required 1/00", door, lamps); end
        wait_close(n);
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL skip_end_idle: dir=%b, required 00", dir); end
        check_served("skip");
    endtask

    task test_door_close;
        int n;
        exp_q.push_back(FS_F2);
        press(7'h20);
        checks++; if (lamps !== 7'h20) begin errors++; $display("FAIL dc_lamp: got %h, required 20", lamps); end
        step(1);
        checks++; if (door !== 1'b1 || lamps !== 7'h00) begin
            errors++; $display("FAIL dc_open_here: door=%b lamps=%h, required 1/00", door, lamps); end
        step(2);
        dc = 1'b1;
        step(1);
        dc = 1'b0;
        checks++; if (door !== 1'b0) begin errors++; $display("FAIL dc_early_close: door=%b, required 0", door); end
        step(1);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL dc_to_idle: state=%0d, required 0", state_dbg); end
        exp_q.push_back(FS_F2);
        press(7'h20);
        step(1);
        step(5);
        checks++; if (door !== 1'b1) begin errors++; $display("FAIL dc_open_cycle6: door=%b, required 1", door); end
        btn = 7'h20;
        dc = 1'b1;
        step(1);
        btn = 7'd0;
        dc = 1'b0;
        checks++; if (door !== 1'b1 || lamps !== 7'h00) begin
            errors++; $display("FAIL dc_press_beats_dc: door=%b lamps=%h, required 1/00", door, lamps); end
        wait_close(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL dc_restart_cycles: got %0d, required 8", n); end
        check_served("dclose");
    endtask

    task test_priority;
        int n;
        exp_q.push_back(FS_F3);
        exp_q.push_back(FS_F1);
        press(7'h41);
        checks++; if (lamps !== 7'h41) begin errors++; $display("FAIL prio_lamps: got %h, required 41", lamps); end
        step(1);
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL prio_above_first: dir=%b, required 01", dir); end
        move_one(FS_F3);
        checks++; if (door !== 1'b1 || lamps !== 7'h01) begin
            errors++; $display("FAIL prio_serve_f3: door=%b lamps=%h, required 1/01", door, lamps); end
        wait_close(n);
        checks++; if (dir !== 2'b10) begin errors++; $display("FAIL prio_reverse: dir=%b, required 10", dir); end
        move_one(FS_F2);
        checks++; if (door !== 1'b0) begin errors++; $display("FAIL prio_pass_f2: door=%b, required 0", door); end
        move_one(FS_F1);
        checks++; if (door !== 1'b1 || lamps !== 7'h00) begin
            errors++; $display("FAIL prio_serve_f1: door=%b lamps=%h, required 1/00", door, lamps); end
        wait_close(n);
        checks++; if (dir !== 2'b00) begin errors++; $display("FAIL prio_end_idle: dir=%b, required 00", dir); end
        check_served("prio");
    endtask

    task test_invariants;
        checks++;
        if (viol_cnt !== 0) begin errors++; $display("FAIL invariant_door_dir: %0d cycles with door=1 and dir!=00 or dir=11, required 0", viol_cnt); end
    endtask

    initial begin
        test_reset;
        test_reset_mid_move;
        test_single_call;
        test_skip_reverse;
        test_door_close;
        test_priority;
        test_invariants;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
